pkt_rr_scheduler: RTL and testbench
===================================

# pkt_rr_scheduler

Packet-level round-robin scheduler that shares one 8-bit byte-stream output between PORT_NUM packet sources. Each source is a show-ahead FIFO whose 9-bit words carry a data byte in [7:0] and a last-byte flag in [8]. The FIFOs sit outside this block and are written by head_and_tail_add instances. The block sits in the hardware control point packet switch ahead of the shared egress byte stream, and replaces fixed-priority selection with fair, gap-enforcing arbitration plus a runaway-packet watchdog.

## Interface
Parameters:
- PORT_NUM, 4: number of sources; 2..8.
- PORT_W, 3: width of the port index; must satisfy 2^PORT_W ≥ PORT_NUM.
- GAP_CYCLES, 23: number of cycles spent in GAP_S after each packet.
- MAX_PKT_LEN, 2047: maximum number of bytes per packet before the watchdog cuts it; 11-bit counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_sched_en  in  1  when 0, no new grants are issued; a packet in flight completes.
- iv_fifo_empty  in  PORT_NUM  per-source FIFO empty flag.
- iv_fifo_rdata  in  9*PORT_NUM  per-source show-ahead FIFO q. Port p uses [9p+8:9p].
- ov_fifo_rden  out  PORT_NUM  per-source read enable, registered; at most one bit is set at a time.
- ov_data  out  8  output byte.
- o_data_wr  out  1  output byte valid.
- ov_grant_port  out  PORT_W  index of the port currently or last granted.
- o_busy  out  1  high while in GRANT_S or XMIT_S.
- o_timeout  out  1  one-cycle pulse when the watchdog truncates a packet.

## Operation
- Reset values: all outputs 0; state IDLE_S; RR pointer last_port = PORT_NUM-1, so port 0 has first priority; counters 0.
- State IDLE_S:
  - ov_data=0 and o_data_wr=0.
  - If i_sched_en=1 and any source is non-empty, pick the first non-empty port scanning last_port+1, last_port+2, … modulo PORT_NUM.
  - For the chosen port g: set ov_fifo_rden[g]<=1, ov_grant_port<=g, last_port<=g, byte_cnt<=0, then go to GRANT_S.
- States GRANT_S and XMIT_S behave identically apart from naming; GRANT_S is always the first byte.
  - Each cycle: ov_data<=q_g[7:0], o_data_wr<=1, byte_cnt<=byte_cnt+1.
  - The FIFO pops on every cycle where rden=1.
  - If q_g[8]=1: set rden<=0 and go to GAP_S. This applies in GRANT_S too, so 1-byte packets are legal.
  - Else if byte_cnt == MAX_PKT_LEN-1: set rden<=0, pulse o_timeout, and go to GAP_S. The remaining bytes of that packet are later scheduled as a separate packet; this is accepted behaviour.
  - Else stay in or enter XMIT_S.
- A source FIFO underflowing mid-packet is a source error and is not checked; sources write whole packets only.
- State GAP_S:
  - ov_data<=0, o_data_wr<=0, gap_cnt<=gap_cnt+1.
  - When gap_cnt == GAP_CYCLES-1: clear gap_cnt and go to IDLE_S.
- Unknown state: outputs are 0 and the state goes to IDLE_S.
- Dropping i_sched_en mid-packet has no effect until the packet reaches IDLE_S.
- Asynchronous reset mid-packet: all outputs drop immediately. The FIFOs share this reset through aclr, so no partial packet survives.

## Timing
- Latency: FIFO non-empty sampled in IDLE_S at cycle t; rden=1 from t+1; first byte on ov_data with o_data_wr=1 at t+2.
- Back-to-back bytes: one byte per cycle with no bubbles inside a packet.
- If the last word is popped at cycle T:
  - The last byte is output at T+1.
  - o_data_wr is 0 from T+2 through T+GAP_CYCLES+2.
  - The earliest next first byte is at T+GAP_CYCLES+3, i.e. a minimum idle of GAP_CYCLES+1 cycles.
- The grant decision is made only in IDLE_S; a packet is never interleaved with another.
- Fairness: with all ports continuously backlogged, grants go 0,1,…,PORT_NUM-1,0,…

## Structure
- Shared package pkt_switch_pkg holds:
  - State encodings IDLE_S=0, GRANT_S=1, XMIT_S=2, GAP_S=3.
  - Constants LAST_BIT=8 and DATA_W=8.
- One sub-module, rr_pick: combinational rotate, priority-encode, un-rotate. Inputs: request vector and last_port. Outputs: grant index and grant-valid.
- The source FIFOs stay outside this block.

## Test plan
- Reset, then port 2 holds 3-byte packet A1,A2,A3 (last on A3): rden[2] is high for 3 cycles, and ov_data shows A1,A2,A3 on consecutive cycles starting 2 cycles after non-empty.
- All 4 ports each hold two 4-byte packets: grant order is 0,1,2,3,0,1,2,3, and every inter-packet o_data_wr low run is exactly 24 cycles with GAP_CYCLES=23.
- 1-byte packet 0x5A on port 1: one output byte 0x5A with o_data_wr high for 1 cycle, and rden[1] high for exactly 1 cycle.
- MAX_PKT_LEN=16 with a 20-byte packet on port 0: 16 bytes output, o_timeout pulses once, then after the gap the last 4 bytes are output as a new packet.
- i_sched_en dropped during byte 3 of a 10-byte packet: all 10 bytes are sent, and there is no new grant until i_sched_en=1.
- i_rst_n asserted mid-packet: o_data_wr, ov_fifo_rden and o_busy go to 0 asynchronously; after release, grant order restarts at port 0.

Source files
------------

// File: rtl/pkt_switch_pkg.sv
// Shared types and constants for the packet switch egress path.
// Word layout: data byte in [7:0], last-byte flag in [8].
package pkt_switch_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    GRANT_S = 2'd1,
    XMIT_S  = 2'd2,
    GAP_S   = 2'd3
  } state_e;

  localparam int LAST_BIT = 8;
  localparam int DATA_W   = 8;
  localparam int WORD_W   = 9;
  localparam int CNT_W    = 11;

endpackage

// File: rtl/pkt_rr_scheduler_if.sv
// Request/grant bundle between the scheduler FSM and the
// round-robin picker.
interface pkt_rr_scheduler_if #(
  parameter int PORT_NUM = 4,
  parameter int PORT_W   = 3
);

  logic [PORT_NUM-1:0] req;
  logic [PORT_W-1:0]   last_port;
  logic [PORT_W-1:0]   grant;
  logic                grant_vld;

  modport master (
    output req,
    output last_port,
    input  grant,
    input  grant_vld
  );

  modport slave (
    input  req,
    input  last_port,
    output grant,
    output grant_vld
  );

endinterface

// File: rtl/pkt_rr_scheduler_rr_pick.sv
// Round-robin pick: rotate requests past last_port, take the
// lowest set bit, then map the offset back to a port index.
module rr_pick #(
  parameter int PORT_NUM = 4,
  parameter int PORT_W   = 3
) (
  pkt_rr_scheduler_if.slave pick
);

  logic [2*PORT_NUM-2:0] dbl;
  logic [PORT_NUM-1:0]   rot;
  int                    sh;
  int                    idx;

  always_comb begin
    sh  = (int'(pick.last_port) + 1) % PORT_NUM;
    dbl = {pick.req[PORT_NUM-2:0], pick.req};
    rot = dbl[sh +: PORT_NUM];
    idx = 0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (rot[i]) idx = i;
    end
    pick.grant_vld = |rot;
    pick.grant     = PORT_W'((sh + idx) % PORT_NUM);
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Packet-level round-robin scheduler with inter-packet gap
// and a runaway-packet watchdog.
module pkt_rr_scheduler
  import pkt_switch_pkg::*;
#(
  parameter int PORT_NUM    = 4,
  parameter int PORT_W      = 3,
  parameter int GAP_CYCLES  = 23,
  parameter int MAX_PKT_LEN = 2047
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_sched_en,
  input  logic [PORT_NUM-1:0]        iv_fifo_empty,
  input  logic [WORD_W*PORT_NUM-1:0] iv_fifo_rdata,
  output logic [PORT_NUM-1:0]        ov_fifo_rden,
  output logic [DATA_W-1:0]          ov_data,
  output logic                       o_data_wr,
  output logic [PORT_W-1:0]          ov_grant_port,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [PORT_NUM-1:0]   rden_q, rden_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  wr_q, wr_d;
  logic [PORT_W-1:0]     grant_q, grant_d;
  logic [PORT_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [WORD_W-1:0]     q_g;

  pkt_rr_scheduler_if #(
    .PORT_NUM (PORT_NUM),
    .PORT_W   (PORT_W)
  ) pick_if ();

  assign pick_if.req =
    ~iv_fifo_empty & {PORT_NUM{i_sched_en}};
  assign pick_if.last_port = last_q;

  rr_pick #(
    .PORT_NUM (PORT_NUM),
    .PORT_W   (PORT_W)
  ) u_pick (
    .pick (pick_if)
  );

  always_comb begin
    q_g = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (grant_q == PORT_W'(p))
        q_g = iv_fifo_rdata[WORD_W*p +: WORD_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rden_d     = rden_q;
    data_d     = '0;
    wr_d       = 1'b0;
    grant_d    = grant_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE_S: begin
        rden_d = '0;
        if (pick_if.grant_vld) begin
          rden_d     = PORT_NUM'(1) << pick_if.grant;
          grant_d    = pick_if.grant;
          last_d     = pick_if.grant;
          byte_cnt_d = '0;
          state_d    = GRANT_S;
        end
      end
      GRANT_S, XMIT_S: begin
        data_d     = q_g[DATA_W-1:0];
        wr_d       = 1'b1;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        if (q_g[LAST_BIT]) begin
          rden_d  = '0;
          state_d = GAP_S;
        end else if (byte_cnt_q == CNT_LAST) begin
          // Cut here; the tail is rescheduled as a new packet.
          rden_d    = '0;
          timeout_d = 1'b1;
          state_d   = GAP_S;
        end else begin
          state_d = XMIT_S;
        end
      end
      GAP_S: begin
        rden_d    = '0;
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE_S;
        end
      end
      default: begin
        rden_d    = '0;
        grant_d   = '0;
        gap_cnt_d = '0;
        state_d   = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE_S;
      rden_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      grant_q    <= '0;
      last_q     <= PORT_W'(PORT_NUM - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rden_q     <= rden_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ov_fifo_rden  = rden_q;
  assign ov_data       = data_q;
  assign o_data_wr     = wr_q;
  assign ov_grant_port = grant_q;
  assign o_timeout     = timeout_q;
  assign o_busy        = (state_q == GRANT_S) ||
                         (state_q == XMIT_S);

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Bench for pkt_rr_scheduler: FIFO models, timeline model of
// expected outputs, and directed scenario checks.
module tb_pkt_rr_scheduler;

  localparam int N    = 4;
  localparam int PW   = 3;
  localparam int GAP  = 23;
  localparam int MAXL = 16;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            en    = 1'b0;
  logic [N-1:0]    empty;
  logic [9*N-1:0]  rdata;
  logic [N-1:0]    rden;
  logic [7:0]      data;
  logic            wr;
  logic [PW-1:0]   gport;
  logic            busy;
  logic            tmo;

  always #5 clk = ~clk;

  pkt_rr_scheduler #(
    .PORT_NUM    (N),
    .PORT_W      (PW),
    .GAP_CYCLES  (GAP),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sched_en    (en),
    .iv_fifo_empty (empty),
    .iv_fifo_rdata (rdata),
    .ov_fifo_rden  (rden),
    .ov_data       (data),
    .o_data_wr     (wr),
    .ov_grant_port (gport),
    .o_busy        (busy),
    .o_timeout     (tmo)
  );

  pkt_rr_scheduler_if #(.PORT_NUM(N), .PORT_W(PW)) pk_if ();
  rr_pick #(.PORT_NUM(N), .PORT_W(PW)) u_pick (
    .pick (pk_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // Show-ahead source FIFOs
  logic [8:0]   fq[N][$];
  logic [N-1:0] rd_s;

  function automatic void refresh();
    for (int p = 0; p < N; p++) begin
      empty[p] = (fq[p].size() == 0);
      rdata[9*p +: 9] = empty[p] ? 9'h0 : fq[p][0];
    end
  endfunction

  initial refresh();

  always @(posedge clk) begin
    rd_s = rden;
    #1;
    for (int p = 0; p < N; p++)
      if (rd_s[p] && fq[p].size() > 0)
        void'(fq[p].pop_front());
    refresh();
  end

  always @(negedge rst_n) begin
    for (int p = 0; p < N; p++) fq[p].delete();
    refresh();
  end

  task automatic push_pkt(input int p, input int len,
                          input logic [7:0] base);
    for (int i = 0; i < len; i++)
      fq[p].push_back({(i == len - 1), 8'(base + i)});
    refresh();
  endtask

  // Timeline model: cycle-indexed expected outputs
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   ex_data[int];
  logic [N-1:0] ex_rden[int];
  bit           ex_to[int];
  int           ex_gr[int];
  int  next_dec = 0;
  int  last_p   = N - 1;
  int  cur_gr   = 0;
  int  m_g, m_p, m_l;
  bit  m_done;

  // Output log
  int         b_len[$];
  int         b_port[$];
  int         b_first[$];
  logic [7:0] b_bytes[$];
  int         lowrun[$];
  int         rden_cnt[N];
  int         to_cnt;
  bit         in_b, seen_b;
  int         cur_len, low_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      ex_data.delete(); ex_rden.delete();
      ex_to.delete();   ex_gr.delete();
      last_p = N - 1;
      cur_gr = 0;
      next_dec = cyc + 1;
    end
    if (ex_gr.exists(cyc)) cur_gr = ex_gr[cyc];
    chk("wr", wr, ex_data.exists(cyc));
    chk("data", data,
        ex_data.exists(cyc) ? ex_data[cyc] : 8'h0);
    chk("rden", rden,
        ex_rden.exists(cyc) ? ex_rden[cyc] : '0);
    chk("busy", busy, ex_rden.exists(cyc));
    chk("timeout", tmo, ex_to.exists(cyc));
    chk("grant", gport, cur_gr);

    if (rst_n && cyc >= next_dec) begin
      m_g = -1;
      if (en)
        for (int k = 1; k <= N; k++) begin
          m_p = (last_p + k) % N;
          if (m_g < 0 && fq[m_p].size() > 0) m_g = m_p;
        end
      if (m_g < 0) next_dec = cyc + 1;
      else begin
        m_l = 0;
        m_done = 0;
        while (!m_done && m_l < MAXL &&
               m_l < fq[m_g].size()) begin
          if (fq[m_g][m_l][8]) m_done = 1;
          m_l++;
        end
        for (int k = 0; k < m_l; k++) begin
          ex_rden[cyc+1+k] = N'(1) << m_g;
          ex_data[cyc+2+k] = fq[m_g][k][7:0];
        end
        ex_gr[cyc+1] = m_g;
        if (!m_done) ex_to[cyc+1+m_l] = 1;
        next_dec = cyc + m_l + GAP + 1;
        last_p = m_g;
      end
    end

    for (int p = 0; p < N; p++)
      if (rden[p]) rden_cnt[p]++;
    if (tmo) to_cnt++;
    if (wr) begin
      if (!in_b) begin
        in_b = 1;
        cur_len = 0;
        if (seen_b) lowrun.push_back(low_cnt);
        b_first.push_back(cyc);
        b_port.push_back(int'(gport));
      end
      b_bytes.push_back(data);
      cur_len++;
    end else begin
      if (in_b) begin
        b_len.push_back(cur_len);
        in_b = 0;
        seen_b = 1;
        low_cnt = 0;
      end
      low_cnt++;
    end
  end

  task automatic clear_logs();
    b_len.delete(); b_port.delete(); b_first.delete();
    b_bytes.delete(); lowrun.delete();
    for (int p = 0; p < N; p++) rden_cnt[p] = 0;
    to_cnt = 0; in_b = 0; seen_b = 0;
    cur_len = 0; low_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++)
      if (fq[p].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int t = 0;
    while (!(all_empty() && cyc >= next_dec && !in_b) &&
           t < budget) begin
      tick();
      t++;
    end
    if (t >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: not idle after %0d cycles, want idle",
               nm, budget);
    end
  endtask

  int tv_req[7] = '{4'b1010, 4'b1010, 4'b0001, 4'b1111,
                    4'b1111, 4'b0100, 4'b0000};
  int tv_lst[7] = '{3, 1, 0, 3, 0, 2, 1};
  int tv_g[7]   = '{1, 3, 0, 0, 1, 2, 0};
  int tv_v[7]   = '{1, 1, 1, 1, 1, 1, 0};
  int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int t_push;

  initial begin
    for (int i = 0; i < 7; i++) begin
      pk_if.req = N'(tv_req[i]);
      pk_if.last_port = PW'(tv_lst[i]);
      #1;
      chk("pick_vld", pk_if.grant_vld, tv_v[i]);
      if (tv_v[i] == 1) chk("pick_g", pk_if.grant, tv_g[i]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", wr, 0);
    chk("rst_data", data, 0);
    chk("rst_rden", rden, 0);
    chk("rst_grant", gport, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    en = 1;

    // All ports backlogged with two 4-byte packets each
    clear_logs();
    tick();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        push_pkt(p, 4, 8'(16 * p + 4 * r));
    wait_idle("rr_idle", 1500);
    chk("rr_nburst", b_len.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", b_port[i], exp_ord[i]);
      chk("rr_len", b_len[i], 4);
    end
    chk("rr_ngap", lowrun.size(), 7);
    foreach (lowrun[i]) chk("rr_gap", lowrun[i], 24);

    // 3-byte packet on port 2
    clear_logs();
    tick();
    push_pkt(2, 3, 8'hA1);
    t_push = cyc;
    wait_idle("p2_idle", 200);
    chk("p2_nburst", b_len.size(), 1);
    chk("p2_port", b_port[0], 2);
    chk("p2_lat", b_first[0] - t_push, 2);
    chk("p2_b0", b_bytes[0], 8'hA1);
    chk("p2_b1", b_bytes[1], 8'hA2);
    chk("p2_b2", b_bytes[2], 8'hA3);
    chk("p2_rden", rden_cnt[2], 3);

    // 1-byte packet on port 1
    clear_logs();
    tick();
    push_pkt(1, 1, 8'h5A);
    wait_idle("one_idle", 200);
    chk("one_nburst", b_len.size(), 1);
    chk("one_len", b_len[0], 1);
    chk("one_byte", b_bytes[0], 8'h5A);
    chk("one_rden", rden_cnt[1], 1);

    // 20-byte packet truncated at 16
    clear_logs();
    tick();
    push_pkt(0, 20, 8'h10);
    wait_idle("wd_idle", 400);
    chk("wd_nburst", b_len.size(), 2);
    chk("wd_len0", b_len[0], 16);
    chk("wd_len1", b_len[1], 4);
    chk("wd_tmo", to_cnt, 1);
    chk("wd_b15", b_bytes[15], 8'h1F);
    chk("wd_b16", b_bytes[16], 8'h20);
    chk("wd_b19", b_bytes[19], 8'h23);
    chk("wd_gap", lowrun[0], 24);

    // Scheduler disabled mid-packet
    clear_logs();
    tick();
    push_pkt(3, 10, 8'h30);
    repeat (4) tick();
    en = 0;
    push_pkt(1, 2, 8'h40);
    repeat (80) tick();
    chk("en_nburst", b_len.size(), 1);
    chk("en_len", b_len[0], 10);
    chk("en_b9", b_bytes[9], 8'h39);
    chk("en_rden1", rden_cnt[1], 0);
    en = 1;
    wait_idle("en_idle", 300);
    chk("en_nburst2", b_len.size(), 2);
    chk("en_port2", b_port[1], 1);
    chk("en_b10", b_bytes[10], 8'h40);

    // Asynchronous reset mid-packet
    tick();
    push_pkt(2, 8, 8'h60);
    repeat (5) tick();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_wr", wr, 0);
    chk("arst_rden", rden, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    clear_logs();
    tick();
    push_pkt(3, 1, 8'h73);
    push_pkt(0, 1, 8'h70);
    wait_idle("arst_idle", 300);
    chk("arst_nburst", b_len.size(), 2);
    chk("arst_first", b_port[0], 0);
    chk("arst_second", b_port[1], 3);
    chk("arst_b0", b_bytes[0], 8'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: sim time %0t exceeded",
             $time);
    $fatal(1, "timeout");
  end

endmodule
